bus_copy_master: RTL

//  Requesting end of the shared-bus req/grant handshake: a bus master that raises m_req,

---
 rtl/bus_pkg.sv | 28 ++
 rtl/copy_addr_gen.sv | 67 ++++++
 rtl/bus_copy_master.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Definitions shared by the bus arbiter, the bus slaves and the copy master:
// default bus widths and the copy-master state encoding.
// ---------------------------------------------------------------------------
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_LEN_W  = 8;

    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_REQ_ENC     = 3'd1;
    localparam logic [2:0] ST_RD_ADDR_ENC = 3'd2;
    localparam logic [2:0] ST_RD_DATA_ENC = 3'd3;
    localparam logic [2:0] ST_WR_ENC      = 3'd4;
    localparam logic [2:0] ST_DONE_ENC    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_REQ     = ST_REQ_ENC,
        ST_RD_ADDR = ST_RD_ADDR_ENC,
        ST_RD_DATA = ST_RD_DATA_ENC,
        ST_WR      = ST_WR_ENC,
        ST_DONE    = ST_DONE_ENC
    } copy_state_t;

endpackage

// File: rtl/copy_addr_gen.sv
// ---------------------------------------------------------------------------
// copy_addr_gen
// Holds the latched copy command (source base, destination base, length)
// and the index of the word currently being copied. Produces the read and
// write addresses for that word and flags the last word of the burst.
// Address arithmetic wraps modulo 2^ADDR_W.
//
// Ports
//   clk, reset_n    clock, asynchronous active-low reset
//   load            latch src_addr/dst_addr/len and clear the index
//   advance         current word has been written; step to the next word
//   src_addr        first source word address of the command
//   dst_addr        first destination word address of the command
//   len             number of words in the command
//   rd_addr         source address of the current word
//   rd_addr_next    source address of the following word
//   wr_addr         destination address of the current word
//   last            current word is the final word of the burst
// ---------------------------------------------------------------------------
module copy_addr_gen
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int LEN_W  = BUS_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] rd_addr_next,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last
);

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  index;
    logic [ADDR_W-1:0] index_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            index <= '0;
        end else if (load) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= len;
            index <= '0;
        end else if (advance) begin
            index <= index + LEN_W'(1);
        end
    end

    assign index_addr   = ADDR_W'(index);
    assign rd_addr      = src_q + index_addr;
    assign rd_addr_next = src_q + index_addr + ADDR_W'(1);
    assign wr_addr      = dst_q + index_addr;
    assign last         = ((index + LEN_W'(1)) == len_q);

endmodule

// File: rtl/bus_copy_master.sv
// ---------------------------------------------------------------------------
// bus_copy_master
// Bus master that copies len words from src_addr.. to dst_addr.. over the
// shared req/grant bus. Each word costs three granted cycles: read address,
// read data, write. Words are copied in ascending order with no overlap
// protection; addresses wrap modulo 2^ADDR_W.
//
// Bus handshake: m_req is held high from REQ through the last WR of the
// burst. The arbiter answers with m_grant one clock after m_req. A bus
// cycle only counts when m_grant is high in that cycle; if grant is lost
// the current word is restarted from its read once grant returns, and
// m_wr is gated so a write is never presented while ungranted. Read data
// on m_din is valid the cycle after the read address is presented.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   command pulse, accepted only in IDLE
//   src_addr/dst_addr/len   command fields, latched on an accepted start
//   busy                    command in progress (REQ..WR)
//   done                    one-cycle completion pulse
//   m_req, m_grant          bus request / grant
//   m_wr, m_addr, m_dout    bus cycle type, address, write data
//   m_din                   bus read data
//   dbg_state               current FSM state encoding
// ---------------------------------------------------------------------------
module bus_copy_master
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W,
    parameter int LEN_W  = BUS_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              m_req,
    input  logic              m_grant,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din,
    output logic [2:0]        dbg_state
);

    copy_state_t       state, state_next;
    logic              busy_next, done_next, req_next, wr_q, wr_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] word_buf, buf_next;
    logic              load, advance;
    logic [ADDR_W-1:0] rd_addr, rd_addr_next, wr_addr;
    logic              last;

    copy_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (load),
        .advance      (advance),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len          (len),
        .rd_addr      (rd_addr),
        .rd_addr_next (rd_addr_next),
        .wr_addr      (wr_addr),
        .last         (last)
    );

    // State and all outputs are registered together; the output values are
    // decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            m_req    <= 1'b0;
            wr_q     <= 1'b0;
            m_addr   <= '0;
            word_buf <= '0;
        end else begin
            state    <= state_next;
            busy     <= busy_next;
            done     <= done_next;
            m_req    <= req_next;
            wr_q     <= wr_next;
            m_addr   <= addr_next;
            word_buf <= buf_next;
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = m_addr;
        buf_next   = word_buf;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        load       = 1'b1;
                        state_next = ST_REQ;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (m_grant) begin
                    state_next = ST_RD_ADDR;
                    addr_next  = rd_addr;
                end
            end
            ST_RD_ADDR: begin
                state_next = m_grant ? ST_RD_DATA : ST_REQ;
            end
            ST_RD_DATA: begin
                if (!m_grant) begin
                    state_next = ST_REQ;
                end else begin
                    state_next = ST_WR;
                    addr_next  = wr_addr;
                    buf_next   = m_din;
                end
            end
            ST_WR: begin
                // An ungranted write did not happen: keep the index so the
                // word is re-read and written again after regrant.
                if (!m_grant) begin
                    state_next = ST_REQ;
                end else begin
                    advance = 1'b1;
                    if (last) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_RD_ADDR;
                        addr_next  = rd_addr_next;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_next = 1'b0;
        done_next = 1'b0;
        req_next  = 1'b0;
        wr_next   = 1'b0;
        case (state_next)
            ST_REQ, ST_RD_ADDR, ST_RD_DATA: begin
                busy_next = 1'b1;
                req_next  = 1'b1;
            end
            ST_WR: begin
                busy_next = 1'b1;
                req_next  = 1'b1;
                wr_next   = 1'b1;
            end
            ST_DONE: begin
                done_next = 1'b1;
            end
            default: begin
                busy_next = 1'b0;
            end
        endcase
    end

    // Grant can drop in the middle of a WR cycle; the write strobe must
    // follow it immediately.
    assign m_wr      = wr_q & m_grant;
    assign m_dout    = word_buf;
    assign dbg_state = state;

endmodule
